sprite_renderer: RTL

//  Responder side of the sprite command interface: serves the per-line sprite sequencer.
//  Per sprite: fetches attributes, answers with lb_addr/sprite_width plus a sprite_ready pulse,

---
 rtl/vdp_sprite_pkg.sv | 34 +++
 rtl/sprite_pixel_expand.sv | 26 ++
 rtl/sprite_renderer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vdp_sprite_pkg.sv
// Shared types and constants for the sprite renderer.
//   sprite_attr_t          : 64-bit sprite attribute word as stored in attribute RAM
//   OFF_SCREEN             : linebuffer address reported for sprites not on this line
//   PAT_AW                 : pattern RAM word address width (one word = 8 px x 4bpp)
//   sprite_render_state_t  : renderer FSM states
package vdp_sprite_pkg;

  localparam logic [11:0] OFF_SCREEN = 12'hFF8;
  localparam int          PAT_AW     = 20;

  // Field order is MSB first, so the packing matches the RAM word layout:
  // [63] en, [62:43] base, [42:39] pal, [38] hflip, [37:30] h, [29:22] w,
  // [21:12] y, [11:0] x.
  typedef struct packed {
    logic        en;
    logic [19:0] base;
    logic [3:0]  pal;
    logic        hflip;
    logic [7:0]  h;
    logic [7:0]  w;
    logic [9:0]  y;
    logic [11:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_CALC  = 3'd3,
    ST_READY = 3'd4,
    ST_DRAW  = 3'd5
  } sprite_render_state_t;

endpackage

// File: rtl/sprite_pixel_expand.sv
// Combinational expansion of one pattern word into a linebuffer write.
//   pat_data  in  32  8 px x 4bpp, px0 in [3:0]
//   pal       in  4   palette number placed above every nibble
//   hflip     in  1   reverse pixel order within the word
//   data      out 64  8 px x {pal,nibble}, px0 in [7:0]
//   mask      out 8   per-pixel write enable, 0 where the nibble is 0
module sprite_pixel_expand (
  input  logic [31:0] pat_data,
  input  logic [3:0]  pal,
  input  logic        hflip,
  output logic [63:0] data,
  output logic [7:0]  mask
);

  generate
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_px
      logic [3:0] nib;
      assign nib              = hflip ? pat_data[(7-gi)*4 +: 4] : pat_data[gi*4 +: 4];
      assign data[gi*8 +: 8]  = {pal, nib};
      // Colour index 0 is transparent: leave the linebuffer pixel untouched.
      assign mask[gi]         = |nib;
    end
  endgenerate

endmodule

// File: rtl/sprite_renderer.sv
// Sprite renderer: responder side of the sprite command interface.
// Per sprite it fetches the attribute word, reports the linebuffer start
// address and width with a one-cycle sprite_ready pulse, then turns each
// 8-pixel beat into a masked linebuffer write two cycles later.
//   clk, rst                       clock, async active-high reset
//   line, line_y                   start-of-line pulse and scanline number
//   sprite_index                   sprite to load (sampled in FETCH)
//   sprite_valid, lb_x, sprite_x   beat strobe, linebuffer address, beat number
//   sprite_ready, lb_addr,
//   sprite_width                   per-sprite answer to the sequencer
//   attr_addr / attr_data          attribute RAM (1-cycle read latency)
//   pat_addr / pat_data            pattern RAM (1-cycle read latency)
//   lbw_en/addr/data/mask          linebuffer write port
module sprite_renderer #(
  parameter logic [11:0] OFF_SCREEN = vdp_sprite_pkg::OFF_SCREEN,
  parameter int          PAT_AW     = vdp_sprite_pkg::PAT_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line,
  input  logic [9:0]        line_y,
  input  logic [8:0]        sprite_index,
  input  logic              sprite_valid,
  input  logic [11:0]       lb_x,
  input  logic [10:0]       sprite_x,
  output logic              sprite_ready,
  output logic [11:0]       lb_addr,
  output logic [7:0]        sprite_width,
  output logic [8:0]        attr_addr,
  input  logic [63:0]       attr_data,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [31:0]       pat_data,
  output logic              lbw_en,
  output logic [11:0]       lbw_addr,
  output logic [63:0]       lbw_data,
  output logic [7:0]        lbw_mask
);
  import vdp_sprite_pkg::*;

  sprite_render_state_t state_q, state_d;
  sprite_attr_t         attr_q;
  logic [9:0]           line_y_q;
  logic                 hit_q;
  logic [PAT_AW-1:0]    row_base_q;
  logic [11:0]          lb_addr_q;
  logic [7:0]           width_q;
  logic                 seen_q;      // at least one beat since entering DRAW

  // Stage 1: beat accepted, pattern read in flight
  logic                 s1_valid_q;
  logic                 s1_hit_q;
  logic [11:0]          s1_lbx_q;
  logic [3:0]           s1_pal_q;
  logic                 s1_hflip_q;

  // Stage 2: registered linebuffer write
  logic                 lbw_en_q;
  logic [11:0]          lbw_addr_q;
  logic [63:0]          lbw_data_q;
  logic [7:0]           lbw_mask_q;

  // Row of the sprite on this scanline; wraps so sprites straddling y=0 work.
  logic [9:0]           row;
  logic [8:0]           stride;
  logic [18:0]          stride_prod;
  logic                 hit;
  logic [PAT_AW-1:0]    row_base;

  assign row         = line_y_q - attr_q.y;
  assign stride      = {attr_q.w, 1'b0};
  assign stride_prod = {9'd0, row} * {10'd0, stride};
  assign hit         = attr_q.en && (attr_q.w != 8'd0) && (row < {2'b00, attr_q.h});
  assign row_base    = PAT_AW'(attr_q.base) + PAT_AW'(stride_prod);

  logic                 beat;
  logic [10:0]          last_beat;
  logic [10:0]          beat_off;

  assign beat      = (state_q == ST_DRAW) && sprite_valid;
  assign last_beat = {2'b00, stride} - 11'd1;
  assign beat_off  = attr_q.hflip ? (last_beat - sprite_x) : sprite_x;

  // Pattern address is combinational from the beat so the RAM data lands
  // in the next cycle and the write is registered one cycle after that.
  assign pat_addr     = beat ? (row_base_q + PAT_AW'(beat_off)) : '0;
  assign attr_addr    = (state_q == ST_FETCH) ? sprite_index : 9'd0;
  assign sprite_ready = (state_q == ST_READY);
  assign lb_addr      = lb_addr_q;
  assign sprite_width = width_q;
  assign lbw_en       = lbw_en_q;
  assign lbw_addr     = lbw_addr_q;
  assign lbw_data     = lbw_data_q;
  assign lbw_mask     = lbw_mask_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_CALC;
      ST_CALC:  state_d = ST_READY;
      ST_READY: state_d = ST_DRAW;
      // Falling edge of sprite_valid ends the sprite; without any beat the
      // sequencer has finished the line and we park here until line.
      ST_DRAW:  if (seen_q && !sprite_valid) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    if (line) state_d = ST_FETCH;
  end

  logic [63:0] px_data;
  logic [7:0]  px_mask;
  logic        wr_go;

  sprite_pixel_expand u_expand (
    .pat_data (pat_data),
    .pal      (s1_pal_q),
    .hflip    (s1_hflip_q),
    .data     (px_data),
    .mask     (px_mask)
  );

  // A line pulse discards whatever is in the beat pipeline.
  assign wr_go = s1_valid_q && s1_hit_q && !line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      attr_q     <= '0;
      line_y_q   <= '0;
      hit_q      <= 1'b0;
      row_base_q <= '0;
      lb_addr_q  <= OFF_SCREEN;
      width_q    <= 8'd1;
      seen_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_lbx_q   <= '0;
      s1_pal_q   <= '0;
      s1_hflip_q <= 1'b0;
      lbw_en_q   <= 1'b0;
      lbw_addr_q <= '0;
      lbw_data_q <= '0;
      lbw_mask_q <= '0;
    end else begin
      state_q <= state_d;
      if (line) line_y_q <= line_y;
      if (state_q == ST_LATCH) attr_q <= attr_data;
      // Answer registers change only when a READY pulse follows.
      if (state_q == ST_CALC && !line) begin
        hit_q      <= hit;
        row_base_q <= row_base;
        lb_addr_q  <= hit ? attr_q.x : OFF_SCREEN;
        width_q    <= hit ? attr_q.w : 8'd1;
      end
      seen_q     <= (state_d == ST_DRAW) && (seen_q || beat);
      s1_valid_q <= beat && !line;
      if (beat) begin
        s1_hit_q   <= hit_q;
        s1_lbx_q   <= lb_x;
        s1_pal_q   <= attr_q.pal;
        s1_hflip_q <= attr_q.hflip;
      end
      lbw_en_q   <= wr_go;
      lbw_mask_q <= wr_go ? px_mask : 8'd0;
      if (wr_go) begin
        lbw_addr_q <= s1_lbx_q;
        lbw_data_q <= px_data;
      end
    end
  end

endmodule
